// File: rtl/glb_stream_pkg.sv
// Shared types and defaults for the glb_write block-streaming engine.
package glb_stream_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 1024;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 Fibonacci step, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/glb_write_mem.sv
// Per-block word storage: one synchronous write port, one combinational read port.
module glb_write_mem
  import glb_stream_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/glb_write.sv
// Streams a size header followed by the stored words of each block on a valid/ready port.
// Optional random valid bubbles are enabled by defining GLB_WRITE_BUBBLE_EN.
module glb_write
  import glb_stream_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 1,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cfg_we,
  input  logic                     cfg_blk,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]        cfg_wdata,
  input  logic                     size_we,
  output logic [DATA_W-1:0]        data,
  output logic                     valid,
  input  logic                     ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t            r_state;
  logic              r_blk;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_size [2];
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_xfer;
  logic              w_cfg_ok;
  logic              w_adv;
  logic              w_last;
  logic              w_has_next;
  logic              w_bubble;
  logic [DATA_W-1:0] w_size_cur;
  logic [DATA_W-1:0] w_size_clamped;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_rd_data [2];

  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

  assign w_xfer         = r_valid && ready;
  assign w_cfg_ok       = !r_busy && (32'(cfg_blk) < NUM_BLOCKS);
  assign w_size_cur     = r_size[r_blk];
  assign w_size_clamped = (32'(cfg_wdata) > DEPTH) ? DATA_W'(DEPTH) : cfg_wdata;
  assign w_last         = (32'(r_cnt) + 32'd1) == 32'(w_size_cur);
  assign w_has_next     = (32'(r_blk) + 32'd1) < NUM_BLOCKS;
  // Read address looks one word ahead on a data transfer so the next word is registered in time.
  assign w_adv          = (r_state == DATA) && w_xfer;
  assign w_rd_addr      = AW'(r_cnt) + AW'(w_adv);
  assign w_rd_word      = w_rd_data[r_blk];

`ifdef GLB_WRITE_BUBBLE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_step(r_lfsr);
  end

  assign w_bubble = r_lfsr[0];
`else
  assign w_bubble = 1'b0;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_blk
    if (g < NUM_BLOCKS) begin : g_mem
      glb_write_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
      ) u_mem (
        .clk     (clk),
        .i_we    (cfg_we && !size_we && w_cfg_ok && (cfg_blk == 1'(g))),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data[g])
      );
    end else begin : g_none
      assign w_rd_data[g] = '0;
    end
  end

  // Size registers; a size write wins over a storage write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_size[i] <= '0;
    end else if (size_we && w_cfg_ok) begin
      r_size[cfg_blk] <= w_size_clamped;
    end
  end

  // Stream FSM; a new word is only presented when none is pending, so bubbles never drop a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_blk   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= HDR;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_blk   <= 1'b0;
            r_cnt   <= '0;
            r_valid <= !w_bubble;
            r_data  <= r_size[0];
          end
        end
        HDR: begin
          if (!r_valid) begin
            r_valid <= !w_bubble;
            r_data  <= w_size_cur;
          end else if (ready) begin
            if (w_size_cur == '0) begin
              r_state <= NEXT;
              r_valid <= 1'b0;
            end else begin
              r_state <= DATA;
              r_valid <= !w_bubble;
              r_data  <= w_rd_word;
            end
          end
        end
        DATA: begin
          if (!r_valid) begin
            r_valid <= !w_bubble;
            r_data  <= w_rd_word;
          end else if (ready) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= NEXT;
              r_valid <= 1'b0;
            end else begin
              r_valid <= !w_bubble;
              r_data  <= w_rd_word;
            end
          end
        end
        NEXT: begin
          if (w_has_next) begin
            r_state <= HDR;
            r_blk   <= 1'b1;
            r_cnt   <= '0;
            r_valid <= !w_bubble;
            r_data  <= r_size[1];
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
